// File: rtl/mult_multicycle.sv
// mult_multicycle
// ----------------
// Iterative shift-and-add multiplier. Each BUSY cycle retires BITS_PER_CYCLE
// bits of the multiplier. A full DATA_WIDTH x DATA_WIDTH product therefore
// takes ceil(DATA_WIDTH / BITS_PER_CYCLE) cycles. Signed operands are handled
// in sign-magnitude form: unsigned magnitudes are multiplied, and the result
// is negated at the end when exactly one operand was negative.
//
// Ports
//   clkIn     in   1     clock, rising edge
//   rstIn     in   1     synchronous active-high reset
//   dataAIn   in   W     multiplicand
//   dataBIn   in   W     multiplier
//   signedIn  in   1     1 = operands are two's complement, 0 = unsigned
//   validIn   in   1     operand request
//   readyOut  out  1     operands are accepted this cycle
//   prodOut   out  2W    full-width product
//   validOut  out  1     prodOut holds a result
//   readyIn   in   1     downstream takes the result
//   busyOut   out  1     an operation is iterating
module mult_multicycle #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 4,
    parameter bit SIGNED_SUPPORT = 1'b1
) (
    input  logic                      clkIn,
    input  logic                      rstIn,
    input  logic [DATA_WIDTH-1:0]     dataAIn,
    input  logic [DATA_WIDTH-1:0]     dataBIn,
    input  logic                      signedIn,
    input  logic                      validIn,
    output logic                      readyOut,
    output logic [2*DATA_WIDTH-1:0]   prodOut,
    output logic                      validOut,
    input  logic                      readyIn,
    output logic                      busyOut
);

    localparam int W  = DATA_WIDTH;
    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = (W + K - 1) / K;
    // The multiplier register is padded to a whole number of K-bit digits.
    // The padding bits above W-1 are always zero.
    localparam int PW = N * K;
    localparam int AW = 2 * W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  mag_a;
    logic [PW-1:0] mag_b;
    logic          neg_flag;
    logic [CW-1:0] count;
    logic [AW-1:0] acc;

    logic          accept;
    logic          handshake;
    logic          signed_mode;
    logic          sign_a;
    logic          sign_b;
    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;
    logic [AW-1:0] term;
    logic [AW-1:0] acc_next;
    logic          last_iter;

    // readyOut is forced low during reset, so nothing is accepted on a reset edge.
    assign readyOut  = !rstIn && ((state == IDLE) || ((state == DONE) && readyIn));
    assign accept    = validIn && readyOut;
    assign handshake = validOut && readyIn;
    assign busyOut   = (state == BUSY);

    assign signed_mode = SIGNED_SUPPORT && signedIn;
    assign sign_a      = signed_mode && dataAIn[W-1];
    assign sign_b      = signed_mode && dataBIn[W-1];
    // Take the magnitude as a W-bit unsigned value. For the most negative
    // input, -(-2^(W-1)) wraps to the bit pattern 2^(W-1). Read as unsigned,
    // that is the correct magnitude.
    assign abs_a       = sign_a ? -dataAIn : dataAIn;
    assign abs_b       = sign_b ? -dataBIn : dataBIn;

    // One partial product per cycle: |A| times the current low digit of |B|,
    // shifted into its place in the accumulator. The running sum never
    // exceeds the final product, so it always fits in 2W bits.
    always_comb begin
        term      = AW'(mag_a) * AW'(mag_b[K-1:0]);
        term      = term << (K * int'(count));
        acc_next  = acc + term;
        last_iter = (count == CW'(N - 1));
    end

    // Main sequencer. A new acceptance reloads the operands and restarts
    // iteration. It can come from IDLE, or from DONE in the same cycle that
    // the previous result is handed off.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state    <= IDLE;
            mag_a    <= '0;
            mag_b    <= '0;
            neg_flag <= 1'b0;
            count    <= '0;
            acc      <= '0;
            prodOut  <= '0;
            validOut <= 1'b0;
        end else if (accept) begin
            state    <= BUSY;
            mag_a    <= abs_a;
            mag_b    <= PW'(abs_b);
            neg_flag <= sign_a ^ sign_b;
            count    <= '0;
            acc      <= '0;
            validOut <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    acc   <= acc_next;
                    mag_b <= mag_b >> K;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        prodOut  <= neg_flag ? -acc_next : acc_next;
                        validOut <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (handshake) begin
                        validOut <= 1'b0;
                        state    <= IDLE;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    validOut <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_multicycle.sv
// tb_mult_multicycle
// -------------------
// Self-checking bench for mult_multicycle. A behavioural model tracks the
// expected product (plain 64-bit arithmetic) and the expected timing of each
// operation. One negedge process compares every output against that model on
// every cycle. Directed sequences cover the reference products, backpressure,
// reset mid-operation and the K=3 / K=32 latencies. Randomized traffic runs
// at the end.
module tb_mult_multicycle;

    localparam int W  = 32;
    localparam int N4 = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  dataA;
    logic [W-1:0]  dataB;
    logic          sgn;
    logic          vin;
    logic          rin;

    logic          ready4, valid4, busy4;
    logic [2*W-1:0] prod4;
    logic          ready3, valid3, busy3;
    logic [2*W-1:0] prod3;
    logic          ready32, valid32, busy32;
    logic [2*W-1:0] prod32;

    int checks = 0;
    int fails  = 0;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    mult_multicycle #(.DATA_WIDTH(W), .BITS_PER_CYCLE(4), .SIGNED_SUPPORT(1'b1)) dut (
        .clkIn(clk), .rstIn(rst), .dataAIn(dataA), .dataBIn(dataB), .signedIn(sgn),
        .validIn(vin), .readyOut(ready4), .prodOut(prod4), .validOut(valid4),
        .readyIn(rin), .busyOut(busy4)
    );

    mult_multicycle #(.DATA_WIDTH(W), .BITS_PER_CYCLE(3), .SIGNED_SUPPORT(1'b1)) dut3 (
        .clkIn(clk), .rstIn(rst), .dataAIn(dataA), .dataBIn(dataB), .signedIn(sgn),
        .validIn(vin), .readyOut(ready3), .prodOut(prod3), .validOut(valid3),
        .readyIn(rin), .busyOut(busy3)
    );

    mult_multicycle #(.DATA_WIDTH(W), .BITS_PER_CYCLE(32), .SIGNED_SUPPORT(1'b1)) dut32 (
        .clkIn(clk), .rstIn(rst), .dataAIn(dataA), .dataBIn(dataB), .signedIn(sgn),
        .validIn(vin), .readyOut(ready32), .prodOut(prod32), .validOut(valid32),
        .readyIn(rin), .busyOut(busy32)
    );

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact reference product from plain 64-bit arithmetic
    function automatic logic [63:0] refProd(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    // Behavioural model of the K=4 instance: phase 0 idle, 1 computing, 2 result held
    int          m_phase = 0;
    int          m_rem   = 0;
    bit          m_valid = 1'b0;
    bit          m_known = 1'b0;
    logic [63:0] m_prod  = '0;
    logic [63:0] m_pend  = '0;
    int          m_results = 0;
    bit          m_take;

    // Model update on each rising edge from the inputs presented for that edge
    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_valid = 1'b0;
            m_prod  = '0;
            m_known = 1'b1;
        end else begin
            m_take = vin && (m_phase == 0 || (m_phase == 2 && rin));
            if (m_phase == 1) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_phase = 2;
                    m_valid = 1'b1;
                    m_prod  = m_pend;
                    m_known = 1'b1;
                    m_results++;
                end
            end else if (m_phase == 2 && rin) begin
                m_phase = 0;
                m_valid = 1'b0;
                m_known = 1'b0;
            end
            if (m_take) begin
                m_pend  = refProd(dataA, dataB, sgn);
                m_rem   = N4;
                m_phase = 1;
                m_known = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of the K=4 instance against the model
    always @(negedge clk) begin
        checkOutput("validOut", 64'(valid4), 64'(m_valid));
        checkOutput("busyOut", 64'(busy4), 64'(m_phase == 1));
        checkOutput("readyOut", 64'(ready4), 64'(!rst && (m_phase == 0 || (m_phase == 2 && rin))));
        if (m_known)
            checkOutput("prodOut", prod4, m_prod);
    end

    // Present inputs for exactly one edge; returns just after that edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input logic v, input logic r);
        dataA = a;
        dataB = b;
        sgn   = s;
        vin   = v;
        rin   = r;
        @(posedge clk);
        #2;
    endtask

    // Count edges until validOut rises, with a bound
    task automatic waitResult(output int lat);
        lat = 0;
        while (!valid4 && lat < 40) begin
            @(posedge clk);
            #2;
            lat++;
        end
        if (!valid4) lat = -1;
    endtask

    // One operation from idle with readyIn held high
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input string name);
        int lat;
        applyStimulus(a, b, s, 1'b1, 1'b1);
        vin = 1'b0;
        waitResult(lat);
        checkOutput({name, " latency"}, 64'(lat), 64'(N4));
        checkOutput({name, " product"}, prod4, exp);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Hard time limit so the bench always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, lat3, lat32, lat4;
        logic [63:0] held, cap3, cap32, cap4;
        bit sawValid;

        rst = 1'b1; dataA = '0; dataB = '0; sgn = 1'b0; vin = 1'b0; rin = 1'b0;

        // Pin the reference model itself to hand-computed products
        checkOutput("model 7x6", refProd(32'd7, 32'd6, 1'b0), 64'd42);
        checkOutput("model -3x5", refProd(32'hFFFF_FFFD, 32'd5, 1'b1), 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("model minxmin", refProd(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);
        checkOutput("model minx1", refProd(32'h8000_0000, 32'd1, 1'b1), 64'hFFFF_FFFF_8000_0000);
        checkOutput("model ones unsigned", refProd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
        checkOutput("model ones signed", refProd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1), 64'h1);
        checkOutput("model big", refProd(32'h1234_5678, 32'h9ABC_DEF0, 1'b0), 64'h0B00_EA4E_242D_2080);

        // Reset state, including readyOut low while reset is held
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset readyOut", 64'(ready4), 64'd0);
        checkOutput("reset validOut", 64'(valid4), 64'd0);
        checkOutput("reset busyOut", 64'(busy4), 64'd0);
        checkOutput("reset prodOut", prod4, 64'd0);
        rst = 1'b0; vin = 1'b0;
        #1;
        checkOutput("ready after reset", 64'(ready4), 64'd1);

        // All three widths start together: K=3, K=4 and K=32 latencies
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b1);
        vin = 1'b0;
        lat3 = -1; lat4 = -1; lat32 = -1;
        cap3 = '0; cap4 = '0; cap32 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #2;
            if (valid3 && lat3 < 0)   begin lat3 = k;  cap3 = prod3;   end
            if (valid4 && lat4 < 0)   begin lat4 = k;  cap4 = prod4;   end
            if (valid32 && lat32 < 0) begin lat32 = k; cap32 = prod32; end
        end
        checkOutput("K3 latency", 64'(lat3), 64'd11);
        checkOutput("K3 product", cap3, 64'h0B00_EA4E_242D_2080);
        checkOutput("K4 latency", 64'(lat4), 64'd8);
        checkOutput("K4 product", cap4, 64'h0B00_EA4E_242D_2080);
        checkOutput("K32 latency", 64'(lat32), 64'd1);
        checkOutput("K32 product", cap32, 64'h0B00_EA4E_242D_2080);

        // Reference products through the K=4 instance
        runOp(32'd7, 32'd6, 1'b0, 64'd42, "7x6");
        runOp(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "-3x5");
        runOp(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "minxmin");
        runOp(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, "minx1");
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "ones unsigned");
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1, "ones signed");

        // Backpressure: the result holds and new requests are ignored
        applyStimulus(32'd1000, 32'd3, 1'b0, 1'b1, 1'b0);
        vin = 1'b0;
        waitResult(lat);
        checkOutput("bp latency", 64'(lat), 64'(N4));
        held = prod4;
        checkOutput("bp product", held, 64'd3000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus($urandom, $urandom, 1'b1, 1'b1, 1'b0);
            checkOutput("bp validOut held", 64'(valid4), 64'd1);
            checkOutput("bp prodOut held", prod4, held);
            checkOutput("bp readyOut low", 64'(ready4), 64'd0);
        end
        // Release with a new request in the same cycle: back-to-back
        applyStimulus(32'd11, 32'd13, 1'b0, 1'b1, 1'b1);
        vin = 1'b0;
        checkOutput("b2b validOut cleared", 64'(valid4), 64'd0);
        checkOutput("b2b busyOut", 64'(busy4), 64'd1);
        waitResult(lat);
        checkOutput("b2b latency", 64'(lat), 64'(N4));
        checkOutput("b2b product", prod4, 64'd143);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);

        // Reset pulsed in the fourth iteration discards the operation
        applyStimulus(32'd100, 32'd200, 1'b0, 1'b1, 1'b1);
        vin = 1'b0;
        repeat (3) applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("ready after mid reset", 64'(ready4), 64'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
            if (valid4) sawValid = 1'b1;
        end
        checkOutput("no result after reset", 64'(sawValid), 64'd0);
        runOp(32'd3, 32'd3, 1'b0, 64'd9, "3x3 after reset");

        // Randomized traffic with occasional resets; the model checks every cycle
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        checkOutput("random results produced", 64'(m_results > 20), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mult_multicycle.md
MULT_MULTICYCLE -- requirements
Module: mult_multicycle

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width W; legal range 2..64.
REQ-002 Parameter BITS_PER_CYCLE, default 4, multiplier bits K retired per iteration; legal range 1..W.
REQ-003 Parameter SIGNED_SUPPORT, default 1; when 0, signedIn SHALL be ignored and all operations are unsigned.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named clkIn and rstIn.
REQ-005 clkIn  input  1  clock; all state updates on the rising edge.
REQ-006 rstIn  input  1  synchronous active-high reset.
REQ-007 dataAIn  input  W  multiplicand.
REQ-008 dataBIn  input  W  multiplier.
REQ-009 signedIn  input  1  1 = both operands two's complement, 0 = both unsigned.
REQ-010 validIn  input  1  operand request.
REQ-011 readyOut  output  1  block accepts operands this cycle.
REQ-012 prodOut  output  2W  full-width product.
REQ-013 validOut  output  1  prodOut holds a valid result.
REQ-014 readyIn  input  1  downstream accepts the result.
REQ-015 busyOut  output  1  an operation is in the BUSY state.

Function
REQ-016 N = ceil(W/K) iterations per operation; when W is not a multiple of K, the multiplier SHALL be zero-padded above bit W-1.
REQ-017 The FSM SHALL have the states IDLE, BUSY and DONE.
  - IDLE: acceptance goes to BUSY.
  - BUSY: after the Nth iteration, goes to DONE.
  - DONE: on validOut&&readyIn, goes to BUSY if a new acceptance occurs in the same cycle, else to IDLE.
REQ-018 readyOut SHALL be combinational: 1 when in IDLE, or in DONE with readyIn=1; otherwise 0, including while rstIn=1.
REQ-019 Acceptance SHALL occur on an edge where validIn&&readyOut; at acceptance the block SHALL register the operands, the sign mode and an iteration counter set to 0.
REQ-020 Signed mode SHALL register |A|, |B| as W-bit unsigned magnitudes plus negFlag = signA XOR signB.
  - |-2^(W-1)| SHALL equal 2^(W-1) without overflow.
REQ-021 Each BUSY edge SHALL:
  - add (|A| x next K bits of |B|), shifted by K x counter, into a 2W-bit accumulator;
  - shift |B| right by K;
  - increment the counter.
REQ-022 On the Nth iteration edge, prodOut SHALL be loaded with the accumulator result, two's-complement negated if negFlag=1, and validOut SHALL be set to 1.
REQ-023 Latency SHALL be exactly N edges from the acceptance edge to the first cycle validOut=1 (W=32, K=4 gives 8; K=W gives 1).
REQ-024 prodOut and validOut SHALL hold stable while validOut=1 and readyIn=0.
REQ-025 validOut SHALL clear on the handshake edge unless a back-to-back acceptance restarts BUSY; in that case validOut also clears.
REQ-026 Peak throughput SHALL be one result per N+1 cycles with readyIn held at 1.
REQ-027 The product SHALL be exact for all operand values; no truncation or saturation is permitted.
REQ-028 validIn asserted while readyOut=0 SHALL be ignored; operands SHALL not be required to be held.
REQ-029 busyOut SHALL be 1 exactly while the state is BUSY.

Reset
REQ-030 rstIn=1 on any edge SHALL force IDLE and clear all outputs, regardless of state.
  - validOut=0, prodOut=0, busyOut=0.
  - The counter and accumulator SHALL be cleared.
REQ-031 Reset mid-operation SHALL discard the operation with no result emitted; the first acceptance after rstIn deasserts SHALL behave as from power-up.
REQ-032 readyOut SHALL be 1 in the first cycle after rstIn deasserts.

Verification
REQ-033 W=32, K=4, unsigned: A=7, B=6 accepted at edge 0 -> validOut=1 after edge 8, prodOut=42, busyOut high for 8 cycles.
REQ-034 Signed: -3 x 5 -> 0xFFFFFFFFFFFFFFF1; 0x80000000 x 0x80000000 -> 0x4000000000000000; 0x80000000 x 1 -> 0xFFFFFFFF80000000.
REQ-035 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001; the same operands in signed mode -> 0x0000000000000001.
REQ-036 Backpressure: readyIn=0 for 5 cycles after validOut rises -> prodOut and validOut stable and readyOut=0; readyIn=1 with validIn=1 -> back-to-back acceptance, next result after N further edges.
REQ-037 Reset mid-op: rstIn pulsed at iteration 4 of 8 -> validOut never rises for that operation; a subsequent 3 x 3 -> 9 after 8 edges.
REQ-038 W=32, K=3 (N=11) and K=32 (N=1): 0x12345678 x 0x9ABCDEF0 unsigned -> 0x0B00EA4E242D2080 at the respective latency.
